rgmii_rx_deserializer: RTL and testbench

- Consumes the per-pin rising/falling samples (q1/q2) from the RGMII input buffer stage and produces a byte stream for the rx MAC.
- Supports 1000 Mb/s DDR and 10/100 Mb/s SDR nibble modes.
- Decodes rx_ctl into data-valid and error.
- Extracts RGMII in-band link status during inter-frame gaps.
- Runs entirely in the buffered rx clock domain.

---
 rtl/rgmii_rx_deserializer.sv | 190 +++++++++++++++++++
 tb/tb_rgmii_rx_deserializer.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rgmii_rx_deserializer.sv
// RGMII receive deserializer: turns q1/q2 pin samples into a byte stream
// with frame delimiting, error reporting and in-band link status.
module rgmii_rx_deserializer #(
  parameter int DATA_WIDTH    = 4,
  parameter int STATUS_FILTER = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [1:0]                link_speed,
  input  logic [DATA_WIDTH:0]       q1,
  input  logic [DATA_WIDTH:0]       q2,
  output logic [2*DATA_WIDTH-1:0]   m_rx_data,
  output logic                      m_rx_valid,
  output logic                      m_rx_last,
  output logic                      m_rx_error,
  output logic                      link_up,
  output logic [1:0]                link_speed_status,
  output logic                      full_duplex
);

  localparam int BW = 2 * DATA_WIDTH;
  localparam logic [3:0] FILT = 4'(STATUS_FILTER);

  typedef enum logic [1:0] {RESYNC, IDLE, FRAME} state_t;

  logic [DATA_WIDTH:0]     q1_q, q2_q;
  state_t                  state_q, state_d;
  logic                    ddr_q, ddr_d;
  logic                    phase_q, phase_d;
  logic [DATA_WIDTH-1:0]   low_q, low_d;
  logic [BW-1:0]           hold_q, hold_d;
  logic                    hold_vld_q, hold_vld_d;
  logic                    err_q, err_d;
  logic [BW-1:0]           data_q, data_d;
  logic                    valid_q, valid_d;
  logic                    last_q, last_d;
  logic                    error_q, error_d;
  logic [3:0]              prev_q, prev_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    link_up_q, link_up_d;
  logic [1:0]              spd_q, spd_d;
  logic                    fdx_q, fdx_d;

  logic                    dv, er, active, take, ddr, frame_end;
  logic [DATA_WIDTH-1:0]   lo, hi;
  logic [3:0]              cand;

  assign dv        = q1_q[DATA_WIDTH];
  assign er        = q1_q[DATA_WIDTH] ^ q2_q[DATA_WIDTH];
  assign lo        = q1_q[DATA_WIDTH-1:0];
  assign hi        = q2_q[DATA_WIDTH-1:0];
  assign cand      = q1_q[3:0];
  assign active    = (state_q != RESYNC);
  assign take      = active && dv;
  assign frame_end = (state_q == FRAME) && !dv;
  // Mode is taken live on the first data cycle, then frozen for the frame.
  assign ddr = (state_q == FRAME) ? ddr_q
             : (link_speed inside {2'b10, 2'b11});

  always_comb begin
    state_d    = state_q;
    ddr_d      = ddr_q;
    phase_d    = phase_q;
    low_d      = low_q;
    hold_d     = hold_q;
    hold_vld_d = 1'b0;
    err_d      = err_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    last_d     = 1'b0;
    error_d    = 1'b0;
    prev_d     = prev_q;
    cnt_d      = cnt_q;
    link_up_d  = link_up_q;
    spd_d      = spd_q;
    fdx_d      = fdx_q;

    unique case (state_q)
      RESYNC: if (!dv) state_d = IDLE;
      IDLE: begin
        if (dv) begin
          state_d = FRAME;
          ddr_d   = ddr;
        end
      end
      FRAME:   if (!dv) state_d = IDLE;
      default: state_d = RESYNC;
    endcase

    if (take) begin
      if (er) err_d = 1'b1;
      if (ddr) begin
        hold_d     = {hi, lo};
        hold_vld_d = 1'b1;
      end else if (!phase_q) begin
        low_d   = lo;
        phase_d = 1'b1;
      end else begin
        hold_d     = {lo, low_q};
        hold_vld_d = 1'b1;
        phase_d    = 1'b0;
      end
    end

    // The held byte leaves one cycle later, once we know whether dv fell.
    if (hold_vld_q) begin
      valid_d = 1'b1;
      data_d  = hold_q;
      last_d  = !dv;
      error_d = !dv && err_q;
    end else if (frame_end && phase_q) begin
      valid_d = 1'b1;
      data_d  = {{DATA_WIDTH{1'b0}}, low_q};
      last_d  = 1'b1;
      error_d = 1'b1;
    end

    if (frame_end) begin
      err_d   = 1'b0;
      phase_d = 1'b0;
    end

    if (active && !dv) begin
      if (er) begin
        cnt_d = 4'd0;
      end else if (cand == prev_q && cnt_q != 4'd0) begin
        if (cnt_q < FILT) cnt_d = cnt_q + 4'd1;
      end else begin
        cnt_d  = 4'd1;
        prev_d = cand;
      end
    end

    if (cnt_q == FILT) begin
      link_up_d = prev_q[0];
      spd_d     = prev_q[2:1];
      fdx_d     = prev_q[3];
    end
  end

  // Input samples are not reset so RESYNC sees the live dv right away.
  always_ff @(posedge clk) begin
    q1_q <= q1;
    q2_q <= q2;
    if (reset) begin
      state_q    <= RESYNC;
      ddr_q      <= 1'b0;
      phase_q    <= 1'b0;
      low_q      <= '0;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      err_q      <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      error_q    <= 1'b0;
      prev_q     <= '0;
      cnt_q      <= '0;
      link_up_q  <= 1'b0;
      spd_q      <= '0;
      fdx_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ddr_q      <= ddr_d;
      phase_q    <= phase_d;
      low_q      <= low_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      err_q      <= err_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
      error_q    <= error_d;
      prev_q     <= prev_d;
      cnt_q      <= cnt_d;
      link_up_q  <= link_up_d;
      spd_q      <= spd_d;
      fdx_q      <= fdx_d;
    end
  end

  assign m_rx_data         = data_q;
  assign m_rx_valid        = valid_q;
  assign m_rx_last         = last_q;
  assign m_rx_error        = error_q;
  assign link_up           = link_up_q;
  assign link_speed_status = spd_q;
  assign full_duplex       = fdx_q;

endmodule

// File: tb/tb_rgmii_rx_deserializer.sv
// Directed bench for rgmii_rx_deserializer: DDR/SDR framing, errors,
// in-band status filtering, reset recovery and mode switching.
module tb_rgmii_rx_deserializer;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] link_speed;
  logic [4:0] q1, q2;
  logic [7:0] m_rx_data;
  logic       m_rx_valid, m_rx_last, m_rx_error;
  logic       link_up, full_duplex;
  logic [1:0] link_speed_status;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [7:0] d;
    logic       last;
    logic       err;
    int         cyc;
  } beat_t;
  beat_t beats[$];

  rgmii_rx_deserializer #(.DATA_WIDTH(4), .STATUS_FILTER(4)) dut (
    .clk(clk), .reset(reset), .link_speed(link_speed),
    .q1(q1), .q2(q2),
    .m_rx_data(m_rx_data), .m_rx_valid(m_rx_valid),
    .m_rx_last(m_rx_last), .m_rx_error(m_rx_error),
    .link_up(link_up), .link_speed_status(link_speed_status),
    .full_duplex(full_duplex)
  );

  always #5 clk = ~clk;

  task automatic step(input logic [4:0] a, input logic [4:0] b);
    q1 = a;
    q2 = b;
    @(posedge clk);
    #1;
    cyc++;
    if (m_rx_valid)
      beats.push_back('{m_rx_data, m_rx_last, m_rx_error, cyc});
  endtask

  task automatic idle(input int n, input logic [3:0] rxd = 4'h0);
    for (int i = 0; i < n; i++) step({1'b0, rxd}, {1'b0, rxd});
  endtask

  task automatic test_reset;
    reset = 1'b1;
    idle(3);
    checks++;
    if ({m_rx_valid, m_rx_data, m_rx_last, m_rx_error} !== 11'h0) begin
      errors++;
      $display("FAIL reset_data: got v=%b d=%h l=%b e=%b want all 0",
               m_rx_valid, m_rx_data, m_rx_last, m_rx_error);
    end
    checks++;
    if ({link_up, link_speed_status, full_duplex} !== 4'h0) begin
      errors++;
      $display("FAIL reset_status: got %b%b%b want 0000",
               link_up, link_speed_status, full_duplex);
    end
    reset = 1'b0;
    idle(6);
    checks++;
    if (beats.size() != 0) begin
      errors++;
      $display("FAIL reset_idle_beats: got %0d want 0", beats.size());
    end
  endtask

  task automatic test_ddr;
    logic [3:0] a [4] = '{4'h5, 4'h6, 4'h7, 4'h8};
    logic [3:0] b [4] = '{4'hA, 4'hB, 4'hC, 4'hD};
    logic [7:0] ed [4] = '{8'hA5, 8'hB6, 8'hC7, 8'hD8};
    int start;
    link_speed = 2'b10;
    idle(2);
    beats.delete();
    start = cyc;
    for (int i = 0; i < 4; i++) step({1'b1, a[i]}, {1'b1, b[i]});
    idle(4);
    checks++;
    if (beats.size() != 4) begin
      errors++;
      $display("FAIL ddr_count: got %0d want 4", beats.size());
    end
    for (int i = 0; i < 4 && i < beats.size(); i++) begin
      checks++;
      if (beats[i].d !== ed[i] || beats[i].last !== (i == 3) ||
          beats[i].err !== 1'b0 || beats[i].cyc != start + 3 + i) begin
        errors++;
        $display("FAIL ddr_beat%0d: got d=%h l=%b e=%b t=%0d want d=%h l=%b e=0 t=%0d",
                 i, beats[i].d, beats[i].last, beats[i].err, beats[i].cyc,
                 ed[i], (i == 3), start + 3 + i);
      end
    end
  endtask

  task automatic test_single;
    link_speed = 2'b11;
    beats.delete();
    step(5'h13, 5'h1C);
    idle(4);
    checks++;
    if (beats.size() != 1 || beats[0].d !== 8'hC3 ||
        beats[0].last !== 1'b1 || beats[0].err !== 1'b0) begin
      errors++;
      $display("FAIL single: got n=%0d d=%h l=%b e=%b want n=1 d=c3 l=1 e=0",
               beats.size(), beats.size() > 0 ? beats[0].d : 8'h0,
               beats.size() > 0 ? beats[0].last : 1'b0,
               beats.size() > 0 ? beats[0].err : 1'b0);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] ed [4] = '{8'h21, 8'h43, 8'h65, 8'h87};
    logic       el [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic       ee [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    link_speed = 2'b10;
    beats.delete();
    step(5'h11, 5'h12);
    step(5'h13, 5'h14);
    idle(1);
    step(5'h15, 5'h06);
    step(5'h17, 5'h18);
    idle(4);
    checks++;
    if (beats.size() != 4) begin
      errors++;
      $display("FAIL b2b_count: got %0d want 4", beats.size());
    end
    for (int i = 0; i < 4 && i < beats.size(); i++) begin
      checks++;
      if (beats[i].d !== ed[i] || beats[i].last !== el[i] ||
          beats[i].err !== ee[i]) begin
        errors++;
        $display("FAIL b2b_beat%0d: got d=%h l=%b e=%b want d=%h l=%b e=%b",
                 i, beats[i].d, beats[i].last, beats[i].err,
                 ed[i], el[i], ee[i]);
      end
    end
  endtask

  task automatic test_100;
    logic [7:0] ed [3] = '{8'h21, 8'h43, 8'h65};
    int start;
    link_speed = 2'b01;
    idle(2);
    beats.delete();
    start = cyc;
    for (int i = 1; i <= 6; i++) step({1'b1, 4'(i)}, {1'b1, 4'(i)});
    idle(4);
    checks++;
    if (beats.size() != 3) begin
      errors++;
      $display("FAIL sdr100_count: got %0d want 3", beats.size());
    end
    for (int i = 0; i < 3 && i < beats.size(); i++) begin
      checks++;
      if (beats[i].d !== ed[i] || beats[i].last !== (i == 2) ||
          beats[i].err !== 1'b0 || beats[i].cyc != start + 4 + 2 * i) begin
        errors++;
        $display("FAIL sdr100_beat%0d: got d=%h l=%b e=%b t=%0d want d=%h l=%b e=0 t=%0d",
                 i, beats[i].d, beats[i].last, beats[i].err, beats[i].cyc,
                 ed[i], (i == 2), start + 4 + 2 * i);
      end
    end
  endtask

  task automatic test_10_odd;
    logic [7:0] ed [4] = '{8'h21, 8'h43, 8'h05, 8'h87};
    logic       el [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic       ee [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    link_speed = 2'b00;
    idle(2);
    beats.delete();
    for (int i = 1; i <= 5; i++)
      step({1'b1, 4'(i)}, {(i != 3), 4'(i)});
    idle(2);
    step(5'h17, 5'h17);
    step(5'h18, 5'h18);
    idle(4);
    checks++;
    if (beats.size() != 4) begin
      errors++;
      $display("FAIL sdr10_count: got %0d want 4", beats.size());
    end
    for (int i = 0; i < 4 && i < beats.size(); i++) begin
      checks++;
      if (beats[i].d !== ed[i] || beats[i].last !== el[i] ||
          beats[i].err !== ee[i]) begin
        errors++;
        $display("FAIL sdr10_beat%0d: got d=%h l=%b e=%b want d=%h l=%b e=%b",
                 i, beats[i].d, beats[i].last, beats[i].err,
                 ed[i], el[i], ee[i]);
      end
    end
  endtask

  task automatic test_status;
    idle(6, 4'h0);
    checks++;
    if ({link_up, link_speed_status, full_duplex} !== 4'b0000) begin
      errors++;
      $display("FAIL status_init: got %b%b%b want 0000",
               link_up, link_speed_status, full_duplex);
    end
    idle(7, 4'b1101);
    checks++;
    if ({link_up, link_speed_status, full_duplex} !== 4'b1101) begin
      errors++;
      $display("FAIL status_up: got up=%b spd=%b fdx=%b want up=1 spd=10 fdx=1",
               link_up, link_speed_status, full_duplex);
    end
    idle(3, 4'b0000);
    idle(7, 4'b1101);
    checks++;
    if ({link_up, link_speed_status, full_duplex} !== 4'b1101) begin
      errors++;
      $display("FAIL status_glitch: got up=%b spd=%b fdx=%b want up=1 spd=10 fdx=1",
               link_up, link_speed_status, full_duplex);
    end
    // Carrier-extend gaps (er=1) must restart the filter.
    for (int i = 0; i < 8; i++) begin
      if (i % 3 == 2) step(5'h00, 5'h10);
      else step(5'h00, 5'h00);
    end
    checks++;
    if ({link_up, link_speed_status, full_duplex} !== 4'b1101) begin
      errors++;
      $display("FAIL status_er_reset: got up=%b spd=%b fdx=%b want up=1 spd=10 fdx=1",
               link_up, link_speed_status, full_duplex);
    end
    idle(7, 4'b0000);
    checks++;
    if ({link_up, link_speed_status, full_duplex} !== 4'b0000) begin
      errors++;
      $display("FAIL status_down: got %b%b%b want 0000",
               link_up, link_speed_status, full_duplex);
    end
  endtask

  task automatic test_reset_mid;
    link_speed = 2'b10;
    idle(2);
    beats.delete();
    step(5'h11, 5'h11);
    reset = 1'b1;
    step(5'h12, 5'h12);
    checks++;
    if ({m_rx_valid, m_rx_last} !== 2'b00) begin
      errors++;
      $display("FAIL rst_mid_clear: got v=%b l=%b want 0 0",
               m_rx_valid, m_rx_last);
    end
    reset = 1'b0;
    for (int i = 3; i <= 5; i++) step({1'b1, 4'(i)}, {1'b1, 4'(i)});
    idle(4);
    checks++;
    if (beats.size() != 0) begin
      errors++;
      $display("FAIL rst_mid_drop: got %0d beats want 0", beats.size());
    end
    step(5'h11, 5'h19);
    step(5'h12, 5'h18);
    step(5'h13, 5'h17);
    idle(4);
    checks++;
    if (beats.size() != 3 || beats[0].d !== 8'h91 || beats[1].d !== 8'h82 ||
        beats[2].d !== 8'h73 || beats[2].last !== 1'b1 ||
        beats[0].last !== 1'b0 || beats[2].err !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_next: got n=%0d want 3 beats 91,82,73 last on 73",
               beats.size());
    end
  endtask

  task automatic test_speed_switch;
    link_speed = 2'b00;
    idle(2);
    beats.delete();
    step(5'h11, 5'h1F);
    step(5'h12, 5'h1F);
    link_speed = 2'b10;
    step(5'h13, 5'h1F);
    step(5'h14, 5'h1F);
    idle(3);
    checks++;
    if (beats.size() != 2 || beats[0].d !== 8'h21 || beats[1].d !== 8'h43 ||
        beats[1].last !== 1'b1 || beats[1].err !== 1'b0) begin
      errors++;
      $display("FAIL switch_nibble: got n=%0d d0=%h want 2 beats 21,43",
               beats.size(), beats.size() > 0 ? beats[0].d : 8'h0);
    end
    beats.delete();
    step(5'h15, 5'h1A);
    step(5'h16, 5'h1B);
    idle(4);
    checks++;
    if (beats.size() != 2 || beats[0].d !== 8'hA5 || beats[1].d !== 8'hB6 ||
        beats[1].last !== 1'b1) begin
      errors++;
      $display("FAIL switch_ddr: got n=%0d d0=%h want 2 beats a5,b6",
               beats.size(), beats.size() > 0 ? beats[0].d : 8'h0);
    end
  endtask

  initial begin
    reset = 1'b1;
    link_speed = 2'b10;
    q1 = '0;
    q2 = '0;
    test_reset;
    test_ddr;
    test_single;
    test_back_to_back;
    test_100;
    test_10_odd;
    test_status;
    test_reset_mid;
    test_speed_switch;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
